// File: rtl/adder_serial_param.sv
// Chunk-serial adder: WIDTH-bit a + b + carry-in, CHUNK bits per clock, valid/ready on both sides.
// Define ADDER_SERIAL_SUB_EN to add the resta input (a - b computed as a + ~b + 1).
module adder_serial_param #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ent_valido,
  output logic             ent_listo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             entAcarreo,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             resta,
`endif
  output logic             sal_valido,
  input  logic             sal_listo,
  output logic [WIDTH-1:0] sum,
  output logic             salAcarreo,
  output logic             desbordamiento,
  output logic             ocupado
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("adder_serial_param: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SUMA, LISTO} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   ch_res;
  logic             b_inv, cin_eff;

  // Subtraction folds into the adder: invert b at capture and force the carry-in.
`ifdef ADDER_SERIAL_SUB_EN
  assign b_inv   = resta;
  assign cin_eff = resta ? 1'b1 : entAcarreo;
`else
  assign b_inv   = 1'b0;
  assign cin_eff = entAcarreo;
`endif

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
    ch_res = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (ent_valido) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{b_inv}};
          carry_d = cin_eff;
          idx_d   = '0;
          state_d = SUMA;
        end
      end
      SUMA: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDXW'(i)) sum_d[i*CHUNK +: CHUNK] = ch_res[CHUNK-1:0];
        end
        carry_d = ch_res[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          cout_d  = ch_res[CHUNK];
          ovf_d   = (a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_res[CHUNK-1]) ^ ch_res[CHUNK];
          idx_d   = '0;
          state_d = LISTO;
        end
      end
      LISTO: begin
        if (sal_listo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ent_listo      = (state_q == IDLE);
  assign sal_valido     = (state_q == LISTO);
  assign ocupado        = (state_q != IDLE);
  assign sum            = sum_q;
  assign salAcarreo     = cout_q;
  assign desbordamiento = ovf_q;

endmodule

// File: doc/adder_serial_param.md
Name: adder_serial_param

Overview:
- Parametrised, chunk-serial successor to the team's fixed 8-bit two-stage ripple adder.
- Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock. Carry is held in a register between chunks, so the carry chain stays short at any WIDTH.
- Valid/ready handshake on input and output; it sits as a drop-in arithmetic unit on datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 16, operand and sum width. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle. 1 <= CHUNK <= WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ent_valido  input  1  input operands valid.
- ent_listo  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- entAcarreo  input  1  carry-in.
- sal_valido  output  1  result valid.
- sal_listo  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- salAcarreo  output  1  carry-out of the MSB chunk.
- desbordamiento  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- ocupado  output  1  high in SUMA or LISTO.

Behaviour:
- Clocking/reset: one clock domain; reset is asynchronous and active-low on rst_n. All state is reset asynchronously.
- Reset values: state=IDLE, ent_listo=1, sal_valido=0, ocupado=0, sum=0, salAcarreo=0, desbordamiento=0. Chunk index and carry register are 0.
- FSM states: IDLE, SUMA, LISTO.
- IDLE:
  - ent_listo=1.
  - On ent_valido=1 at a clock edge: capture a, b, entAcarreo into internal registers; idx=0; go to SUMA.
- SUMA:
  - Each cycle: {c, sum[idx*CHUNK +: CHUNK]} = a_r chunk + b_r chunk + carry_r; carry_r <= c; idx++.
  - On the chunk with idx=NCHUNK-1: latch salAcarreo=c and desbordamiento; go to LISTO.
  - ent_valido is ignored (ent_listo=0).
- LISTO:
  - sal_valido=1. sum, salAcarreo and desbordamiento are held stable.
  - When sal_listo=1 at an edge: go to IDLE, sal_valido drops next cycle.
  - sal_listo=0 holds LISTO indefinitely.
- Latency:
  - Accept at edge k; sal_valido=1 from edge k+NCHUNK.
  - Minimum spacing between accepts is NCHUNK+2 cycles; no accept in the same cycle as result handoff.
- Output hold: sum, salAcarreo and desbordamiento keep the last result in IDLE until the next accept. Sum bits are overwritten chunk by chunk during SUMA and are not valid until LISTO.
- Boundaries:
  - CHUNK=WIDTH gives a single SUMA cycle.
  - Full carry ripple: all-ones + 1 propagates through every chunk via carry_r.
  - Operands and carry-in are sampled only at accept; later changes on a, b or entAcarreo have no effect.
  - Reset in any state aborts the operation and returns immediately to the reset values.
- Arithmetic is unsigned modulo 2^WIDTH, with carry-out reported separately. Sum width is never extended.

Optional Feature:
- Macro: ADDER_SERIAL_SUB_EN.
- Defined:
  - Extra input resta (1 bit), sampled at accept.
  - resta=1 computes a - b as a + ~b + 1; entAcarreo is ignored.
  - salAcarreo=1 means no borrow. desbordamiento means signed subtraction overflow.
- Undefined:
  - No resta port; addition only. Identical to the base behaviour.

Test Plan:
- WIDTH=16, CHUNK=4; a=0x1234, b=0x4321, entAcarreo=0 -> sum=0x5555, salAcarreo=0, desbordamiento=0; sal_valido exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, entAcarreo=0 -> sum=0x0000, salAcarreo=1; additionally, a=0xFFFF, b=0x0000, entAcarreo=1 -> sum=0x0000, salAcarreo=1.
- a=0x7FFF, b=0x0001 -> sum=0x8000, desbordamiento=1, salAcarreo=0.
- Hold sal_listo=0 for 6 cycles in LISTO while toggling a, b and ent_valido -> sum stable, ent_listo=0, no new accept; release -> IDLE, ent_listo=1 one cycle later.
- Assert rst_n=0 two cycles into SUMA -> all outputs at reset values immediately; after release, a=0x0003, b=0x0004 -> sum=0x0007.
- With ADDER_SERIAL_SUB_EN, resta=1, a=0x0005, b=0x0007 -> sum=0xFFFE, salAcarreo=0. Separately, WIDTH=8, CHUNK=8, a=0xF0, b=0x20 -> sum=0x10, salAcarreo=1, latency 1 cycle.
